// File: rtl/pack_xfer_fsm_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pack_xfer_fsm_if
// Brief    : Host-side bus of the pack/transfer engine (source load port,
//            destination read port, start/abort/busy/done handshake).
// Revision : 1.0
// ============================================================================
interface pack_xfer_fsm_if #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 2,
    parameter int SRC_DEPTH = 32,
    parameter int DST_DEPTH = 16
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int SAW   = $clog2(SRC_DEPTH);
    localparam int DAW   = $clog2(DST_DEPTH);
    localparam int CW    = DAW + 1;

    logic             src_wr_en;
    logic [SAW-1:0]   src_wr_addr;
    logic [IN_W-1:0]  src_wr_data;
    logic [DAW-1:0]   dst_rd_addr;
    logic [OUT_W-1:0] dst_rd_data;
    logic             start;
    logic             abort;
    logic [SAW-1:0]   src_base;
    logic [DAW-1:0]   dst_base;
    logic [CW-1:0]    word_count;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] checksum;

    modport master (
        output src_wr_en, src_wr_addr, src_wr_data, dst_rd_addr,
               start, abort, src_base, dst_base, word_count,
        input  dst_rd_data, busy, done, checksum
    );

    modport slave (
        input  src_wr_en, src_wr_addr, src_wr_data, dst_rd_addr,
               start, abort, src_base, dst_base, word_count,
        output dst_rd_data, busy, done, checksum
    );
endinterface
`default_nettype wire

// File: rtl/pack_xfer_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pack_xfer_fsm
// Brief    : Reads RATIO source entries, packs them LSB-first into one wide
//            word and writes it to the destination RAM. Define
//            XFER_CHECKSUM_EN to add an XOR checksum of all written words.
// Revision : 1.0
// ============================================================================
module pack_xfer_fsm #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 2,
    parameter int SRC_DEPTH = 32,
    parameter int DST_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    pack_xfer_fsm_if.slave bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int SAW   = $clog2(SRC_DEPTH);
    localparam int DAW   = $clog2(DST_DEPTH);
    localparam int CW    = DAW + 1;
    localparam int RCW   = $clog2(RATIO + 1);
    localparam logic [RCW-1:0] C_RD_LAST = RCW'(RATIO - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_READ   = 4'b0010,
        S_WRITE  = 4'b0100,
        S_FINISH = 4'b1000
    } state_t;

    state_t           state_q, state_d;
    logic             go_q, go_d;
    logic [SAW-1:0]   src_ptr_q, src_ptr_d;
    logic [DAW-1:0]   dst_ptr_q, dst_ptr_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [RCW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [OUT_W-1:0] pack_q, pack_d;
    logic             done_q, done_d;

    logic [IN_W-1:0]  src_mem [SRC_DEPTH];
    logic [OUT_W-1:0] dst_mem [DST_DEPTH];

    logic [IN_W-1:0]  w_src_rd_data;
    logic [OUT_W-1:0] w_pack_shift;
    logic             w_dst_we;
    logic             w_accept;

    assign w_src_rd_data   = src_mem[src_ptr_q];
    assign bus.dst_rd_data = dst_mem[bus.dst_rd_addr];
    // A start is registered first and acted on one cycle later; go_q blocks re-arming.
    assign w_accept        = (state_q == S_IDLE) && !go_q && bus.start;

    generate
        if (RATIO == 1) begin : g_pack_single
            assign w_pack_shift = w_src_rd_data;
        end else begin : g_pack_shift
            assign w_pack_shift = {w_src_rd_data, pack_q[OUT_W-1:IN_W]};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        go_d      = go_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        rem_d     = rem_q;
        rd_cnt_d  = rd_cnt_q;
        pack_d    = pack_q;
        done_d    = done_q;
        w_dst_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go_q) begin
                    go_d    = 1'b0;
                    state_d = (rem_q != '0) ? S_READ : S_FINISH;
                end else if (w_accept) begin
                    go_d      = 1'b1;
                    src_ptr_d = bus.src_base;
                    dst_ptr_d = bus.dst_base;
                    rem_d     = bus.word_count;
                    rd_cnt_d  = '0;
                    pack_d    = '0;
                    done_d    = 1'b0;
                end
            end
            S_READ: begin
                pack_d    = w_pack_shift;
                src_ptr_d = src_ptr_q + SAW'(1);
                if (rd_cnt_q == C_RD_LAST) begin
                    rd_cnt_d = '0;
                    state_d  = S_WRITE;
                end else begin
                    rd_cnt_d = rd_cnt_q + RCW'(1);
                end
            end
            S_WRITE: begin
                w_dst_we  = 1'b1;
                dst_ptr_d = dst_ptr_q + DAW'(1);
                rem_d     = rem_q - CW'(1);
                state_d   = (rem_q != CW'(1)) ? S_READ : S_FINISH;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything above, including a pending WRITE.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            w_dst_we = 1'b0;
            done_d   = done_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            go_q      <= 1'b0;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            rd_cnt_q  <= '0;
            pack_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_q      <= go_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
            rd_cnt_q  <= rd_cnt_d;
            pack_q    <= pack_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.src_wr_en) begin
            src_mem[bus.src_wr_addr] <= bus.src_wr_data;
        end
        if (w_dst_we) begin
            dst_mem[dst_ptr_q] <= pack_q;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;

`ifdef XFER_CHECKSUM_EN
    logic [OUT_W-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (w_accept) begin
            chk_d = '0;
        end else if (w_dst_we) begin
            chk_d = chk_q ^ pack_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign bus.checksum = chk_q;
`else
    assign bus.checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pack_xfer_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pack_xfer_fsm
// Brief    : Directed bench for pack_xfer_fsm (RATIO=2 and RATIO=4 instances)
//            with a transfer-level reference model.
// Revision : 1.0
// ============================================================================
module tb_pack_xfer_fsm;
    localparam int R1 = 2;
`ifdef XFER_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pack_xfer_fsm_if #(.IN_W(8), .RATIO(2), .SRC_DEPTH(32), .DST_DEPTH(16)) bus ();
    pack_xfer_fsm_if #(.IN_W(8), .RATIO(4), .SRC_DEPTH(32), .DST_DEPTH(16)) bus2 ();

    pack_xfer_fsm #(.IN_W(8), .RATIO(2), .SRC_DEPTH(32), .DST_DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus));
    pack_xfer_fsm #(.IN_W(8), .RATIO(4), .SRC_DEPTH(32), .DST_DEPTH(16)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0]  src_m [32];
    logic [15:0] dst_m [16];
    bit          dst_v [16];
    bit          exp_busy = 1'b0;
    bit          exp_done = 1'b0;
    logic [15:0] exp_chk  = '0;
    bit          cmp_on   = 1'b0;
    bit          peek_en  = 1'b0;
    int          peek_addr = 0;
    logic [15:0] peek_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack_word(input int sb, input int j);
        logic [15:0] w;
        w = '0;
        for (int b = 0; b < R1; b++) w[b*8 +: 8] = src_m[(sb + j*R1 + b) % 32];
        return w;
    endfunction

    // Compare process: checks the RATIO=2 instance on every falling edge.
    initial begin
        int sweep;
        int a;
        sweep = 0;
        bus.dst_rd_addr = '0;
        forever begin
            @(negedge clk);
            a = peek_en ? peek_addr : sweep;
            bus.dst_rd_addr = 4'(a);
            #1;
            if (cmp_on) begin
                chk("busy", 32'(bus.busy), 32'(exp_busy));
                chk("done", 32'(bus.done), 32'(exp_done));
                if (!exp_busy) chk("checksum", 32'(bus.checksum), 32'(exp_chk));
                if (peek_en)
                    chk("dst_peek", 32'(bus.dst_rd_data), 32'(peek_exp));
                else if (!exp_busy && dst_v[a])
                    chk("dst_sweep", 32'(bus.dst_rd_data), 32'(dst_m[a]));
            end
            sweep = (sweep + 1) % 16;
        end
    end

    task automatic load_src(input int base, input int n, input int val0);
        for (int i = 0; i < n; i++) begin
            bus.src_wr_en   = 1'b1;
            bus.src_wr_addr = 5'((base + i) % 32);
            bus.src_wr_data = 8'(val0 + i);
            src_m[(base + i) % 32] = 8'(val0 + i);
            @(posedge clk); #1;
        end
        bus.src_wr_en = 1'b0;
    endtask

    task automatic peek(input int addr, input logic [15:0] exp);
        peek_en = 1'b1; peek_addr = addr; peek_exp = exp;
        @(posedge clk); #1;
        peek_en = 1'b0;
    endtask

    // kind: 0 = run to completion, 1 = abort sampled at edge stop_at,
    // 2 = reset asserted just after edge stop_at. Edge 0 samples start.
    task automatic xfer(input int sb, input int db, input int k, input int kind,
                        input int stop_at, input int repulse_at, input int lit_t);
        int t;
        int words;
        logic [15:0] part;
        logic [15:0] w;
        t = k * (R1 + 1) + 2;
        bus.start = 1'b1;
        bus.src_base = 5'(sb); bus.dst_base = 4'(db); bus.word_count = 5'(k);
        @(posedge clk); #1;
        bus.start = 1'b0;
        exp_done = 1'b0; exp_busy = 1'b0; exp_chk = '0;
        words = k;
        for (int n = 1; n <= t; n++) begin
            if (kind == 1 && n == stop_at) bus.abort = 1'b1;
            if (n == repulse_at) begin
                bus.start = 1'b1; bus.src_base = 5'd17; bus.dst_base = 4'd9; bus.word_count = 5'd1;
            end
            @(posedge clk); #1;
            bus.abort = 1'b0; bus.start = 1'b0;
            if (lit_t > 0 && n == lit_t - 1) chk("done_before_edge", 32'(bus.done), 32'd0);
            if (lit_t > 0 && n == lit_t)     chk("done_at_edge", 32'(bus.done), 32'd1);
            if (kind != 0 && n == stop_at) begin
                words = 0;
                for (int j = 0; j < k; j++) begin
                    if (kind == 1 && (1 + (j+1)*(R1+1)) <  n) words++;
                    if (kind == 2 && (1 + (j+1)*(R1+1)) <= n) words++;
                end
                if (kind == 2) rst = 1'b1;
                exp_busy = 1'b0; exp_done = 1'b0;
                break;
            end
            exp_busy = (n <= t - 1);
            exp_done = (n >= t);
        end
        part = '0;
        for (int j = 0; j < words; j++) begin
            w = pack_word(sb, j);
            dst_m[(db + j) % 16] = w;
            dst_v[(db + j) % 16] = 1'b1;
            part ^= w;
        end
        exp_chk = (kind == 2 || !CHK_ON) ? 16'h0 : part;
        if (kind == 2) begin
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) dst_v[i] = 1'b0;
        for (int i = 0; i < 32; i++) src_m[i] = '0;
        bus.src_wr_en = 1'b0; bus.src_wr_addr = '0; bus.src_wr_data = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.src_base = '0; bus.dst_base = '0; bus.word_count = '0;
        bus2.src_wr_en = 1'b0; bus2.src_wr_addr = '0; bus2.src_wr_data = '0;
        bus2.dst_rd_addr = '0; bus2.start = 1'b0; bus2.abort = 1'b0;
        bus2.src_base = '0; bus2.dst_base = '0; bus2.word_count = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_checksum", 32'(bus.checksum), 32'd0);
        cmp_on = 1'b1;

        // Full 16-word transfer of an incrementing pattern
        load_src(0, 32, 0);
        idle(1);
        xfer(0, 0, 16, 0, 0, 0, 50);
        peek(0, 16'h0100);
        peek(15, 16'h1F1E);
        chk("full_checksum", 32'(bus.checksum), 32'd0);
        idle(18);

        // Source wrap into a non-zero destination base
        xfer(30, 5, 2, 0, 0, 0, 8);
        peek(5, 16'h1F1E);
        peek(6, 16'h0100);
        idle(16);

        // Zero-length request, then abort while idle is ignored
        xfer(0, 0, 0, 0, 0, 0, 2);
        bus.abort = 1'b1;
        idle(1);
        bus.abort = 1'b0;
        idle(3);

        // Abort during the WRITE of word 3 of 8
        load_src(0, 16, 8'h40);
        xfer(0, 0, 8, 1, 13, 0, 0);
        peek(2, 16'h4544);
        peek(3, 16'h0706);
        idle(16);
        xfer(0, 8, 4, 0, 0, 0, 14);
        idle(16);

        // Re-pulsed start while busy, then reset mid-READ
        xfer(2, 10, 6, 2, 5, 3, 0);
        chk("post_rst_done", 32'(bus.done), 32'd0);
        idle(16);
        xfer(4, 12, 3, 0, 0, 0, 11);
        peek(12, 16'h4544);
        idle(16);

        // RATIO=4 instance: single word, hand-computed
        cmp_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus2.src_wr_en = 1'b1;
            bus2.src_wr_addr = 5'(i);
            bus2.src_wr_data = 8'(8'hAA + 8'(i) * 8'h11);
            @(posedge clk); #1;
        end
        bus2.src_wr_en = 1'b0;
        bus2.start = 1'b1; bus2.src_base = '0; bus2.dst_base = '0; bus2.word_count = 5'd1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
            if (n == 3) chk("r4_busy", 32'(bus2.busy), 32'd1);
            if (n == 6) chk("r4_done_before_edge", 32'(bus2.done), 32'd0);
            if (n == 7) chk("r4_done_at_edge", 32'(bus2.done), 32'd1);
        end
        bus2.dst_rd_addr = '0;
        #1;
        chk("r4_dst0", bus2.dst_rd_data, 32'hDDCCBBAA);
        chk("r4_checksum", bus2.checksum, CHK_ON ? 32'hDDCCBBAA : 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pack_xfer_fsm.md
Name: pack_xfer_fsm

Overview:
- Parametrised data-transfer engine that moves bytes from a source store to a wider destination store.
- Reads RATIO consecutive IN_W-bit entries from the source RAM, packs them into one IN_W*RATIO word, and writes that word to the destination RAM.
- Host loads the source through an external write port and reads results through an external async read port.
- Successor to the fixed 8-bit/2:1/32-entry transfer FSM. Adds:
  - programmable base addresses and word count
  - start/busy/done handshake
  - abort
  - source address wrap

Parameters:
- IN_W, 8, source entry width in bits.
- RATIO, 2, source entries packed per destination word (≥1).
- SRC_DEPTH, 32, source RAM entries (power of 2).
- DST_DEPTH, 16, destination RAM entries (power of 2).
- Derived, not overridable:
  - OUT_W = IN_W*RATIO
  - SAW = $clog2(SRC_DEPTH)
  - DAW = $clog2(DST_DEPTH)
  - CW = DAW+1

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_wr_en  in  1  host write strobe into source RAM.
- src_wr_addr  in  SAW  host write address.
- src_wr_data  in  IN_W  host write data.
- dst_rd_addr  in  DAW  host read address, destination RAM (async read).
- dst_rd_data  out  OUT_W  destination RAM read data.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel.
- src_base  in  SAW  first source address, captured on start.
- dst_base  in  DAW  first destination address, captured on start.
- word_count  in  CW  destination words to produce, captured on start.
- busy  out  1  high while a transfer is active.
- done  out  1  completion flag.
- checksum  out  OUT_W  XOR of all written words (see Optional Feature).

Behaviour:
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, checksum = 0
  - all pointers, counters and the pack register = 0
  - RAM contents undefined, not reset.
- FSM, one-hot: IDLE, READ, WRITE, FINISH.
- IDLE:
  - start=1 and word_count≠0: capture src_base, dst_base, word_count; clear done and the pack register; go to READ.
  - start=1 and word_count=0: go to FINISH; no RAM writes.
- READ:
  - Lasts exactly RATIO cycles.
  - Each cycle reads src[src_ptr] combinationally and shifts it into the pack register.
  - Byte k of the word (k=0 first read) lands in bits [k*IN_W +: IN_W], LSB-first.
  - src_ptr increments each READ cycle and wraps modulo SRC_DEPTH (SRC_DEPTH-1 → 0).
- WRITE:
  - One cycle; destination write enable = 1, address dst_ptr, data = packed word.
  - dst_ptr increments and wraps modulo DST_DEPTH.
  - Remaining count decrements: if nonzero → READ, else → FINISH.
- FINISH: one cycle; done set to 1; → IDLE.
- done stays high until the next accepted start or reset.
- busy = 1 in READ, WRITE, FINISH.
- Latency: start sampled at edge 0 → done observed high after edge K*(RATIO+1)+2 for K≥1 words; after edge 2 for K=0.
- start while busy: ignored, no effect on the running transfer.
- abort:
  - In any non-IDLE state: → IDLE next edge; busy=0; done unchanged at 0; no further destination writes.
  - If asserted in WRITE, abort wins and that write is suppressed.
  - Ignored in IDLE.
- Host source write during a transfer is permitted. A same-cycle write and read of one address returns the old contents.
- Host dst_rd_data is valid at all times (async); it reflects a WRITE-cycle update from the next cycle.
- word_count > DST_DEPTH: destination pointer wraps and overwrites earlier words. No error is flagged.
- rst mid-transfer: immediate return to reset values. Destination words already written are retained.

Optional Feature:
- Macro XFER_CHECKSUM_EN.
- Defined:
  - checksum cleared on accepted start.
  - Each WRITE XORs the packed word into checksum.
  - Value is stable and valid while done=1.
  - On abort it holds the partial XOR.
- Undefined: checksum is tied to 0; no accumulator register is synthesised.

Test Plan:
- Defaults; src[0..31]=8'h00..8'h1F; start, src_base=0, dst_base=0, word_count=16 → dst[i]={src[2i+1],src[2i]}, e.g. dst[0]=16'h0100, dst[15]=16'h1F1E; done observed high after edge 50; checksum=16'h0000 with macro.
- src_base=30, word_count=2, dst_base=5 → dst[5]={src[31],src[30]}, dst[6]={src[1],src[0]} (source wrap); other dst entries unchanged.
- word_count=0 → busy high 1 cycle, done=1 after edge 2, no destination writes.
- abort asserted in WRITE of word 3 (word_count=8) → dst[0..2] written, dst[3..] unchanged, busy=0, done=0; a subsequent start runs normally.
- start re-pulsed while busy, then rst pulsed mid-READ → second start ignored; after rst busy=0, done=0, checksum=0; next transfer completes correctly.
- RATIO=4, IN_W=8 build; src[0..3]=8'hAA,8'hBB,8'hCC,8'hDD, word_count=1 → dst[0]=32'hDDCCBBAA, done observed high after edge 7.
